// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer blocks (read and write side).
//   addr_width : buffer index width for a given depth
//   ptr_next   : mod-depth pointer increment, {wrap msb, index}
//   fifo_level : unfetched word count between a write and a read pointer
// Values are passed as int unsigned so both sides can share them at any depth;
// callers truncate the result to their own pointer or level width.
package fifo_pkg;

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // The index wraps to zero after depth-1 and the msb above the index toggles.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth,
                                           input int unsigned aw);
    int unsigned idx;
    int unsigned msb;
    idx = ptr & ((32'd1 << aw) - 32'd1);
    msb = (ptr >> aw) & 32'd1;
    if (idx == depth - 32'd1) begin
      return (msb ^ 32'd1) << aw;
    end
    return ptr + 32'd1;
  endfunction

  function automatic int unsigned fifo_level(input int unsigned wr_ptr,
                                             input int unsigned rd_ptr,
                                             input int unsigned depth,
                                             input int unsigned aw);
    int unsigned mask;
    int unsigned w_idx;
    int unsigned r_idx;
    mask  = (32'd1 << aw) - 32'd1;
    w_idx = wr_ptr & mask;
    r_idx = rd_ptr & mask;
    if (((wr_ptr >> aw) & 32'd1) == ((rd_ptr >> aw) & 32'd1)) begin
      return w_idx - r_idx;
    end
    return depth - r_idx + w_idx;
  endfunction

endpackage

// File: rtl/fifo_rd_ostage.sv
// Two-entry output stage of the FIFO read side: output register, skid register
// and the in-flight read flag (pend). Presents a first-word-fall-through stream.
//   clk, rst : read clock, synchronous active-high reset
//   issue    : a buffer read is issued this cycle; its data arrives next cycle
//   rdata    : buffer read data, meaningful while pend is set
//   ready    : consumer accepts dout this cycle
//   occ      : valid + skid valid + pend (0..3)
//   dout     : output word
//   valid    : dout holds a word
module fifo_rd_ostage #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  ready,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  valid_q, valid_d;
  logic                  skid_v_q, skid_v_d;
  logic                  pend_q;
  logic                  pop;

  always_comb begin
    dout_d   = dout_q;
    valid_d  = valid_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    pop      = valid_q & ready;

    // Skid moves forward before the arriving word is placed, preserving order.
    if (pop) begin
      if (skid_v_q) begin
        dout_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end

    if (pend_q) begin
      if (!valid_d) begin
        dout_d  = rdata;
        valid_d = 1'b1;
      end else begin
        skid_d   = rdata;
        skid_v_d = 1'b1;
      end
    end
  end

  // Reset clears pend, so data returned for a pre-reset read is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= '0;
      skid_q   <= '0;
      valid_q  <= 1'b0;
      skid_v_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      skid_q   <= skid_d;
      valid_q  <= valid_d;
      skid_v_q <= skid_v_d;
      pend_q   <= issue;
    end
  end

  assign occ   = {1'b0, valid_q} + {1'b0, skid_v_q} + {1'b0, pend_q};
  assign dout  = dout_q;
  assign valid = valid_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the arbitrary-depth asynchronous FIFO (read clock domain).
// Owns the mod-depth read pointer, derives empty and fill level from the already
// synchronised binary write pointer, and prefetches into a two-entry output stage.
//   clkr_i, rst_i  : read clock, synchronous active-high reset
//   wr_ptr_i       : synchronised write pointer {msb, index}
//   rd_ptr_o       : registered read pointer {msb, index} for the write domain
//   rd_ptr_buff_o  : buffer read index
//   mem_rden_o     : buffer read strobe, mem_rdata_i valid one cycle later
//   dout_o/valid_o/ready_i : first-word-fall-through output stream
//   empty_o        : no unfetched words in the buffer
//   level_o        : unfetched words in the buffer, 0..FIFO_DEPTH
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 50,
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned ADDR_WIDTH = addr_width(FIFO_DEPTH)
) (
  input  logic                  clkr_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH:0]   wr_ptr_i,
  output logic [ADDR_WIDTH:0]   rd_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_buff_o,
  output logic                  mem_rden_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  empty_o,
  output logic [ADDR_WIDTH-1:0] level_o
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]          occ;
  logic [1:0]          occ_after_pop;
  logic                pop;

  // Full-width compare: the msb distinguishes empty from a full buffer.
  assign empty_o = (rd_ptr_q == wr_ptr_i);
  assign level_o = ADDR_WIDTH'(fifo_level(32'(wr_ptr_i), 32'(rd_ptr_q), FIFO_DEPTH, ADDR_WIDTH));

  // Keep at most two words fetched beyond the consumer; a pop this cycle frees a slot.
  assign pop           = valid_o & ready_i;
  assign occ_after_pop = occ - {1'b0, pop};
  assign mem_rden_o    = ~empty_o & (occ_after_pop < 2'd2);

  assign rd_ptr_d = PTR_W'(ptr_next(32'(rd_ptr_q), FIFO_DEPTH, ADDR_WIDTH));

  always_ff @(posedge clkr_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
    end else if (mem_rden_o) begin
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_ptr_o      = rd_ptr_q;
  assign rd_ptr_buff_o = rd_ptr_q[ADDR_WIDTH-1:0];

  fifo_rd_ostage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ostage (
    .clk  (clkr_i),
    .rst  (rst_i),
    .issue(mem_rden_o),
    .rdata(mem_rdata_i),
    .ready(ready_i),
    .occ  (occ),
    .dout (dout_o),
    .valid(valid_o)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl at depth 5: a write-side model fills a buffer model and
// queues expected words and read addresses; a monitor compares them as the DUT
// issues reads and hands off words.
module tb_fifo_rd_ctrl;

  localparam int unsigned DEPTH = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] rd_ptr_buff;
  logic          mem_rden;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] dout;
  logic          valid;
  logic          ready;
  logic          empty;
  logic [AW-1:0] level;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .DATA_WIDTH(DW)
  ) dut (
    .clkr_i       (clk),
    .rst_i        (rst),
    .wr_ptr_i     (wr_ptr),
    .rd_ptr_o     (rd_ptr),
    .rd_ptr_buff_o(rd_ptr_buff),
    .mem_rden_o   (mem_rden),
    .mem_rdata_i  (mem_rdata),
    .dout_o       (dout),
    .valid_o      (valid),
    .ready_i      (ready),
    .empty_o      (empty),
    .level_o      (level)
  );

  // Synchronous-read buffer model.
  logic [DW-1:0] mem [0:7];
  always @(posedge clk) begin
    if (mem_rden) mem_rdata <= mem[rd_ptr_buff];
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int n_reads = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW:0]   ptr_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [AW:0] bench_next(input logic [AW:0] p);
    if (p[AW-1:0] == 3'd4) return {~p[AW], 3'b000};
    return p + 4'd1;
  endfunction

  // Write side: store the word, expect it in order, and expect a read at this address.
  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr[AW-1:0]] = d;
    exp_q.push_back(d);
    ptr_q.push_back(wr_ptr);
    wr_ptr = bench_next(wr_ptr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit chk);
    rst    = 1'b1;
    wr_ptr = '0;
    ready  = 1'b0;
    exp_q.delete();
    ptr_q.delete();
    tick();
    tick();
    if (chk) begin
      check("reset_rd_ptr", 32'(rd_ptr), 0);
      check("reset_rd_ptr_buff", 32'(rd_ptr_buff), 0);
      check("reset_empty", 32'(empty), 1);
      check("reset_valid", 32'(valid), 0);
      check("reset_level", 32'(level), 0);
      check("reset_rden", 32'(mem_rden), 0);
      check("reset_dout", 32'(dout), 0);
    end
    rst = 1'b0;
  endtask

  // Monitor: every read must hit the next expected address; every hand-off the next word.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rden) begin
        n_reads++;
        if (ptr_q.size() == 0) check("read_unexpected", 32'(rd_ptr), -1);
        else check("read_addr", 32'(rd_ptr), 32'(ptr_q.pop_front()));
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) check("dout_unexpected", 32'(dout), -1);
        else check("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    wr_ptr = '0;
    ready  = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset values, then one idle cycle.
    do_reset(1'b1);
    tick();
    check("idle_empty", 32'(empty), 1);
    check("idle_rden", 32'(mem_rden), 0);

    // Single word: read issued the cycle wr_ptr moves, valid two cycles later.
    ready = 1'b1;
    push_word(8'hA5);
    #1;
    check("single_rden", 32'(mem_rden), 1);
    check("single_level", 32'(level), 1);
    tick();
    check("single_rd_ptr", 32'(rd_ptr), 1);
    check("single_valid_t1", 32'(valid), 0);
    tick();
    check("single_valid_t2", 32'(valid), 1);
    check("single_dout", 32'(dout), 32'h A5);
    tick();
    check("single_valid_t3", 32'(valid), 0);
    check("single_empty", 32'(empty), 1);

    // Wrap: 12 words, one per cycle, delivered back to back.
    do_reset(1'b0);
    ready   = 1'b1;
    n_reads = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) push_word(8'(16 + i));
      if (i >= 2) check("wrap_no_bubble", 32'(valid), 1);
      tick();
    end
    check("wrap_valid_end", 32'(valid), 0);
    check("wrap_rd_ptr_end", 32'(rd_ptr), 2);
    check("wrap_reads", n_reads, 12);
    check("wrap_empty", 32'(empty), 1);

    // Back-pressure: only two words fetched ahead, head word held.
    do_reset(1'b0);
    ready   = 1'b0;
    n_reads = 0;
    for (int k = 0; k < 5; k++) push_word(8'(8'hB0 + k));
    repeat (5) tick();
    check("bp_reads", n_reads, 2);
    check("bp_rd_ptr", 32'(rd_ptr), 2);
    check("bp_level", 32'(level), 3);
    check("bp_valid", 32'(valid), 1);
    check("bp_dout_held", 32'(dout), 32'h B0);
    check("bp_empty", 32'(empty), 0);
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_stream_valid", 32'(valid), 1);
      tick();
    end
    check("bp_valid_end", 32'(valid), 0);

    // Level with the write pointer one lap ahead: wr=4'b1001, rd=4'b0011.
    do_reset(1'b0);
    ready = 1'b1;
    for (int k = 0; k < 3; k++) push_word(8'(8'hC0 + k));
    repeat (6) tick();
    check("lw_rd_ptr", 32'(rd_ptr), 3);
    ready = 1'b0;
    for (int k = 3; k < 6; k++) push_word(8'(8'hC0 + k));
    #1;
    check("lw_level", 32'(level), 3);
    check("lw_empty", 32'(empty), 0);
    ready = 1'b1;
    repeat (6) tick();
    check("lw_valid_end", 32'(valid), 0);
    check("lw_rd_ptr_end", 32'(rd_ptr), 9);
    check("lw_empty_end", 32'(empty), 1);

    // Reset while a word is held and another is in flight.
    do_reset(1'b0);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) push_word(8'(8'hD0 + k));
    tick();
    tick();
    check("mr_valid_before", 32'(valid), 1);
    check("mr_dout_before", 32'(dout), 32'h D0);
    rst    = 1'b1;
    wr_ptr = '0;
    exp_q.delete();
    ptr_q.delete();
    tick();
    check("mr_valid_after", 32'(valid), 0);
    check("mr_rd_ptr_after", 32'(rd_ptr), 0);
    rst   = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("mr_no_stale", 32'(valid), 0);
      tick();
    end

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the team's arbitrary-depth asynchronous FIFO, the counterpart to the write-side pointer block. It sits entirely in the read clock domain. It owns the mod-counter read pointer, and derives empty and fill level from the already-synchronised write pointer. It prefetches from the synchronous-read buffer into a two-entry output stage, so consumers see a first-word-fall-through valid/ready stream at one word per cycle.

## Interface
- FIFO_DEPTH, 50: number of buffer entries; any integer ≥ 2.
- DATA_WIDTH, 8: word width.
- ADDR_WIDTH, localparam $clog2(FIFO_DEPTH+1): buffer index width; the full pointer is ADDR_WIDTH+1 bits, {wrap MSB, index}.
- clkr_i  in  1  read-domain clock; the only clock.
- rst_i  in  1  reset, synchronous, active-high.
- wr_ptr_i  in  ADDR_WIDTH+1  write pointer, already synchronised and converted to binary.
- rd_ptr_o  out  ADDR_WIDTH+1  registered read pointer {msb, index}, sent to the write domain.
- rd_ptr_buff_o  out  ADDR_WIDTH  buffer read address (the index only).
- mem_rden_o  out  1  buffer read strobe; data is returned on the next cycle.
- mem_rdata_i  in  DATA_WIDTH  buffer read data, valid one cycle after mem_rden_o.
- dout_o  out  DATA_WIDTH  output word.
- valid_o  out  1  dout_o holds a word.
- ready_i  in  1  consumer accepts dout_o.
- empty_o  out  1  buffer holds no unfetched words (rd_ptr_o == wr_ptr_i).
- level_o  out  ADDR_WIDTH  unfetched words in the buffer, range 0..FIFO_DEPTH.

## Operation
- **Pointer update.** On each read the index increments. At index FIFO_DEPTH-1 the index wraps to 0 and the MSB toggles.
- **Empty.** empty_o = (rd_ptr_o == wr_ptr_i) on all bits. It is combinational from registers and wr_ptr_i.
- **Level.** If the MSBs are equal, level = w_idx - r_idx. Otherwise level = FIFO_DEPTH - r_idx + w_idx. Compute in ADDR_WIDTH+1 bits and truncate.
- **Output stage.** Two entries, the output register and a skid register, plus one in-flight flag (pend).
  - pop = valid_o & ready_i.
  - occ = valid_o + skid_v + pend.
- **Read issue.** mem_rden_o = ~empty_o & ((occ - pop) < 2). When mem_rden_o is high, the pointer advances and pend is set for the next cycle.
- **Fill order.** On pop, the skid word moves to the output register first. Arriving data (pend==1) goes to the output register if it will be empty after this cycle; otherwise it goes to skid.
- **Hold rule.** While valid_o=1 and ready_i=0, dout_o and valid_o are stable. ready_i is ignored while valid_o=0.
- **States (derived from occ).**
  - EMPTY: occ=0.
  - PRIME: pend only.
  - ONE: output register only, or output register plus pend.
  - FULL: output and skid registers occupied, no reads issued.
- **Illegal input.** A wr_ptr_i index ≥ FIFO_DEPTH is illegal and is not checked.

## Timing
- **Reset.** rd_ptr_o=0, rd_ptr_buff_o=0, mem_rden_o=0 (empty), dout_o=0, valid_o=0, skid_v=0, pend=0, empty_o=1 while wr_ptr_i=0, level_o=0.
- **Latency.** wr_ptr_i leaves rd_ptr_o in cycle t → mem_rden_o in t → rd_ptr_o updates at t+1 → valid_o high in t+2.
- **Throughput.** With ready_i held high, one word per cycle is sustained indefinitely.
- **Back-pressure.** At most 2 words are fetched beyond the consumer. No word is lost or duplicated.
- **Simultaneous events.** A pop and an arrival in the same cycle keep ordering: output ← skid, skid ← arrival.
- **Wrap and empty.** Wrap and empty evaluated together in one cycle are correct: the next-pointer compare uses the registered pointer.
- **Reset mid-operation.** Any in-flight word is discarded and mem_rdata_i is ignored in the following cycle. The write side is reset in the same window.

## Structure
- **Shared package fifo_pkg.**
  - ADDR_WIDTH derivation function.
  - Mod-pointer next-value function, shared with the write side.
  - Level arithmetic function.
- **Sub-module fifo_rd_ostage.** Holds the output register, skid register and pend tracking. Its inputs are arrival/data/ready; its outputs are occ, dout and valid.
- **Top level.** Holds the pointer, empty, level and read-issue logic.

## Test plan
All scenarios use FIFO_DEPTH=5, ADDR_WIDTH=3.
- **Reset.** rst_i high 2 cycles, wr_ptr_i=0 → rd_ptr_o=0, empty_o=1, valid_o=0, level_o=0, mem_rden_o=0.
- **Single word.** wr_ptr_i 0→1 in cycle t, mem_rdata_i=0xA5 → mem_rden_o in t; rd_ptr_o=1 in t+1; valid_o=1, dout_o=0xA5 in t+2. With ready_i=1, valid_o=0 in t+3.
- **Wrap.** 12-word stream, ready_i=1 → rd_ptr_o follows 0,1,2,3,4,8,9,10,11,12,0,1,2 → 12 words delivered in order, no bubbles after the first.
- **Back-pressure.** wr_ptr_i=5, ready_i=0 → exactly 2 reads, rd_ptr_o=2, level_o=3, dout_o=word0 held. Then ready_i=1 → words 0..4 delivered on consecutive cycles.
- **Level across wrap.** wr_ptr_i=4'b1001, rd_ptr_o=4'b0011 → level_o=3, empty_o=0.
- **Reset mid-stream.** rst_i asserted with pend=1, valid_o=1 → next cycle valid_o=0, rd_ptr_o=0; mem_rdata_i returned that cycle does not appear on dout_o.
